nios2_ram2_sample_writer: RTL and testbench



---
 rtl/nios2_ram2_pkg.sv | 24 ++
 rtl/nios2_ram2_sample_writer_if.sv | 45 ++++
 rtl/nios2_ram2_csr.sv | 81 ++++++++
 rtl/nios2_ram2_sample_writer.sv | 125 ++++++++++++
 tb/tb_nios2_ram2_sample_writer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios2_ram2_pkg.sv
// Shared constants and types for the RAM port-2 sample writer:
// CSR word map, CTRL bit positions and the writer FSM state type.
package nios2_ram2_pkg;

  localparam logic [1:0] CSR_CTRL   = 2'd0;
  localparam logic [1:0] CSR_STATUS = 2'd1;
  localparam logic [1:0] CSR_ACK    = 2'd2;
  localparam logic [1:0] CSR_DROP   = 2'd3;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_DROP = 1;
  localparam int unsigned CTRL_IRQ  = 2;
  localparam int unsigned CTRL_CLR  = 3;
  localparam int unsigned CTRL_W    = 3;

  localparam int unsigned DROP_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_e;

endpackage

// File: rtl/nios2_ram2_sample_writer_if.sv
// Bundle of the sample stream, RAM port-2 master and CSR slave signals.
// slave = the writer block, master = whatever drives it.
interface nios2_ram2_sample_writer_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned BE_W   = 2
);
  logic              snk_valid;
  logic [DATA_W-1:0] snk_data;
  logic              snk_ready;

  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect;
  logic              ram_write;
  logic [BE_W-1:0]   ram_byteenable;
  logic [DATA_W-1:0] ram_writedata;
  logic              ram_clken;

  logic [1:0]        csr_address;
  logic              csr_chipselect;
  logic              csr_read;
  logic              csr_write;
  logic [31:0]       csr_writedata;
  logic [31:0]       csr_readdata;

  logic              irq;

  modport slave (
    input  snk_valid, snk_data,
    output snk_ready,
    output ram_address, ram_chipselect, ram_write, ram_byteenable, ram_writedata, ram_clken,
    input  csr_address, csr_chipselect, csr_read, csr_write, csr_writedata,
    output csr_readdata,
    output irq
  );

  modport master (
    output snk_valid, snk_data,
    input  snk_ready,
    input  ram_address, ram_chipselect, ram_write, ram_byteenable, ram_writedata, ram_clken,
    output csr_address, csr_chipselect, csr_read, csr_write, csr_writedata,
    input  csr_readdata,
    input  irq
  );
endinterface

// File: rtl/nios2_ram2_csr.sv
// Avalon-MM CSR slave for the sample writer: CTRL register, registered read
// mux, and combinational clear/ACK strobes decoded straight from the write.
module nios2_ram2_csr
  import nios2_ram2_pkg::*;
#(
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        csr_address,
  input  logic              csr_chipselect,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  input  logic [1:0]        full,
  input  logic              stalled,
  input  logic              running,
  input  logic [ADDR_W-1:0] wr_ptr,
  input  logic [DROP_W-1:0] drop_cnt,
  output logic              enable,
  output logic              drop_mode,
  output logic              irq_en,
  output logic              clear,
  output logic [1:0]        ack
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              wr_sel, rd_sel;
  logic              unused_wdata;

  assign unused_wdata = ^csr_writedata[31:CTRL_CLR+1];

  // Clear and ACK act in the write cycle itself so they can pre-empt a
  // concurrent accept; the read mux samples pre-write register values.
  always_comb begin
    wr_sel  = csr_chipselect & csr_write;
    rd_sel  = csr_chipselect & csr_read;
    ctrl_d  = ctrl_q;
    clear   = 1'b0;
    ack     = 2'b00;
    rdata_d = '0;
    if (wr_sel && csr_address == CSR_CTRL) begin
      ctrl_d = csr_writedata[CTRL_W-1:0];
      clear  = csr_writedata[CTRL_CLR];
    end
    if (wr_sel && csr_address == CSR_ACK) begin
      ack = csr_writedata[1:0];
    end
    if (rd_sel) begin
      case (csr_address)
        CSR_CTRL:   rdata_d[CTRL_W-1:0] = ctrl_q;
        CSR_STATUS: begin
          rdata_d[1:0]        = full;
          rdata_d[2]          = stalled;
          rdata_d[3]          = running;
          rdata_d[8 +: ADDR_W] = wr_ptr;
        end
        CSR_DROP:   rdata_d[DROP_W-1:0] = drop_cnt;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= '0;
      rdata_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      rdata_q <= rdata_d;
    end
  end

  assign csr_readdata = rdata_q;
  assign enable       = ctrl_q[CTRL_EN];
  assign drop_mode    = ctrl_q[CTRL_DROP];
  assign irq_en       = ctrl_q[CTRL_IRQ];

endmodule

// File: rtl/nios2_ram2_sample_writer.sv
// Streams 16-bit samples into RAM port 2 as a two-half ping-pong buffer,
// raising irq when a half fills and stalling or dropping until it is ACKed.
module nios2_ram2_sample_writer
  import nios2_ram2_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned BE_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  nios2_ram2_sample_writer_if.slave  bus
);

  localparam int unsigned HALF_MSB = ADDR_W - 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]          full_q, full_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic                irq_q, irq_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;

  logic                enable, drop_mode, irq_en, clear;
  logic [1:0]          ack;
  logic                snk_ready;
  logic                accept, do_write, do_drop;
  logic [1:0]          set;

  nios2_ram2_csr #(.ADDR_W(ADDR_W)) u_csr (
    .clk            (clk),
    .reset          (reset),
    .csr_address    (bus.csr_address),
    .csr_chipselect (bus.csr_chipselect),
    .csr_read       (bus.csr_read),
    .csr_write      (bus.csr_write),
    .csr_writedata  (bus.csr_writedata),
    .csr_readdata   (bus.csr_readdata),
    .full           (full_q),
    .stalled        (state_q == STALL),
    .running        (state_q == RUN),
    .wr_ptr         (wr_ptr_q),
    .drop_cnt       (drop_cnt_q),
    .enable         (enable),
    .drop_mode      (drop_mode),
    .irq_en         (irq_en),
    .clear          (clear),
    .ack            (ack)
  );

  // Datapath: pointer, half-full flags, drop counter and RAM write pulse.
  always_comb begin
    accept     = bus.snk_valid & snk_ready;
    do_write   = accept && (state_q == RUN) && !clear;
    do_drop    = accept && (state_q == STALL) && !clear;
    set        = 2'b00;
    if (do_write && (&wr_ptr_q[ADDR_W-2:0])) begin
      set[wr_ptr_q[HALF_MSB]] = 1'b1;
    end
    full_d     = (full_q & ~ack) | set;
    wr_ptr_d   = do_write ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    drop_cnt_d = (do_drop && drop_cnt_q != '1) ? drop_cnt_q + DROP_W'(1) : drop_cnt_q;
    if (clear) begin
      full_d     = '0;
      wr_ptr_d   = '0;
      drop_cnt_d = '0;
    end
    ram_we_d   = do_write;
    ram_addr_d = do_write ? wr_ptr_q : ram_addr_q;
    ram_data_d = do_write ? bus.snk_data : ram_data_q;
    irq_d      = irq_en & (|full_d);
  end

  // FSM: stall whenever the half the pointer will sit in is still full.
  always_comb begin
    snk_ready = 1'b0;
    state_d   = state_q;
    case (state_q)
      RUN:     snk_ready = 1'b1;
      STALL:   snk_ready = drop_mode;
      default: snk_ready = 1'b0;
    endcase
    if (!enable) begin
      state_d = IDLE;
    end else if (full_d[wr_ptr_d[HALF_MSB]]) begin
      state_d = STALL;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      full_q     <= '0;
      drop_cnt_q <= '0;
      irq_q      <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      full_q     <= full_d;
      drop_cnt_q <= drop_cnt_d;
      irq_q      <= irq_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

  assign bus.snk_ready      = snk_ready;
  assign bus.ram_address    = ram_addr_q;
  assign bus.ram_chipselect = ram_we_q;
  assign bus.ram_write      = ram_we_q;
  assign bus.ram_byteenable = {BE_W{1'b1}};
  assign bus.ram_writedata  = ram_data_q;
  assign bus.ram_clken      = 1'b1;
  assign bus.irq            = irq_q;

endmodule

// File: tb/tb_nios2_ram2_sample_writer.sv
// Directed bench for the RAM port-2 sample writer with a RAM-write scoreboard.
module tb_nios2_ram2_sample_writer;
  import nios2_ram2_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  nios2_ram2_sample_writer_if #(.ADDR_W(7), .DATA_W(16), .BE_W(2)) bus ();

  nios2_ram2_sample_writer #(.ADDR_W(7), .DATA_W(16), .BE_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0]  addr;
    logic [15:0] data;
    int unsigned acc_cyc;
  } wr_t;

  wr_t sb[$];
  logic [6:0] mptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input logic [1:0] f, input bit stl, input bit run,
                                     input logic [6:0] p);
    return {17'b0, p, 4'b0, run, stl, f};
  endfunction

  // Every RAM write must match the oldest expected write, one cycle after accept.
  always @(negedge clk) begin
    if (!reset && bus.ram_chipselect === 1'b1) begin
      wr_t e;
      chk("ram_write_with_cs", 32'(bus.ram_write), 32'd1);
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(bus.ram_address), 32'(e.addr));
        chk("wr_data", 32'(bus.ram_writedata), 32'(e.data));
        chk("wr_latency", cyc, e.acc_cyc + 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    bus.csr_chipselect = 1'b1;
    bus.csr_write      = 1'b1;
    bus.csr_address    = a;
    bus.csr_writedata  = d;
    @(negedge clk);
    bus.csr_chipselect = 1'b0;
    bus.csr_write      = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    bus.csr_chipselect = 1'b1;
    bus.csr_read       = 1'b1;
    bus.csr_address    = a;
    @(negedge clk);
    d = bus.csr_readdata;
    bus.csr_chipselect = 1'b0;
    bus.csr_read       = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input bit exp_wr, input logic [6:0] a);
    int unsigned w;
    wr_t e;
    w = 0;
    bus.snk_valid = 1'b1;
    bus.snk_data  = d;
    while (bus.snk_ready !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (bus.snk_ready !== 1'b1) begin
      chk("ready_timeout", 32'(bus.snk_ready), 32'd1);
      bus.snk_valid = 1'b0;
      return;
    end
    if (exp_wr) begin
      e.addr = a; e.data = d; e.acc_cyc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.snk_valid = 1'b0;
  endtask

  task automatic stream(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      send(base + 16'(i), 1'b1, mptr);
      mptr = mptr + 7'd1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    wr_t e;
    bus.snk_valid = 1'b0; bus.snk_data = '0;
    bus.csr_address = '0; bus.csr_chipselect = 1'b0; bus.csr_read = 1'b0;
    bus.csr_write = 1'b0; bus.csr_writedata = '0;
    mptr = '0;

    // Reset values
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_ready", 32'(bus.snk_ready), 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk("rst_cs", 32'(bus.ram_chipselect), 32'd0);
    chk("rst_we", 32'(bus.ram_write), 32'd0);
    chk("rst_be", 32'(bus.ram_byteenable), 32'h3);
    chk("rst_clken", 32'(bus.ram_clken), 32'd1);
    chk("rst_addr", 32'(bus.ram_address), 32'd0);
    chk("rst_wdata", 32'(bus.ram_writedata), 32'd0);
    chk("rst_rdata", bus.csr_readdata, 32'd0);
    csr_rd(CSR_STATUS, rd); chk("rst_status", rd, 32'd0);
    csr_rd(CSR_CTRL, rd);   chk("rst_ctrl", rd, 32'd0);
    csr_rd(CSR_DROP, rd);   chk("rst_drop", rd, 32'd0);
    chk("rdata_idle", bus.csr_readdata, 32'd0);

    // Basic write
    csr_wr(CSR_CTRL, 32'h1);
    chk("ready_before_run", 32'(bus.snk_ready), 32'd0);
    tick(1);
    chk("ready_run", 32'(bus.snk_ready), 32'd1);
    stream(10, 16'h1000);
    tick(2);
    chk("sb_empty_basic", 32'(sb.size()), 32'd0);
    csr_rd(CSR_STATUS, rd); chk("status_basic", rd, st(2'b00, 0, 1, 7'd10));
    csr_wr(CSR_CTRL, 32'h0);
    tick(1);
    chk("ready_disabled", 32'(bus.snk_ready), 32'd0);
    csr_rd(CSR_STATUS, rd); chk("status_idle_kept", rd, st(2'b00, 0, 0, 7'd10));

    // Half fill and irq
    csr_wr(CSR_CTRL, 32'h5);
    tick(1);
    stream(53, 16'h2000);
    chk("irq_pre", 32'(bus.irq), 32'd0);
    stream(1, 16'h203F);
    chk("irq_rise", 32'(bus.irq), 32'd1);
    csr_rd(CSR_STATUS, rd); chk("status_half0", rd, st(2'b01, 0, 1, 7'd64));
    csr_wr(CSR_ACK, 32'h1);
    chk("irq_fall", 32'(bus.irq), 32'd0);
    csr_rd(CSR_STATUS, rd); chk("status_ack0", rd, st(2'b00, 0, 1, 7'd64));

    // Second half, ignored ACK of empty half, then stall with both halves full
    stream(64, 16'h3000);
    csr_rd(CSR_STATUS, rd); chk("status_half1", rd, st(2'b10, 0, 1, 7'd0));
    csr_wr(CSR_ACK, 32'h1);
    csr_rd(CSR_STATUS, rd); chk("ack_not_full_ignored", rd, st(2'b10, 0, 1, 7'd0));
    csr_wr(CSR_ACK, 32'h2);
    stream(64, 16'h4000);
    stream(64, 16'h5000);
    chk("ready_stall", 32'(bus.snk_ready), 32'd0);
    chk("irq_stall", 32'(bus.irq), 32'd1);
    csr_rd(CSR_STATUS, rd); chk("status_stall", rd, st(2'b11, 1, 0, 7'd0));
    csr_wr(CSR_ACK, 32'h1);
    chk("ready_resume", 32'(bus.snk_ready), 32'd1);
    stream(1, 16'h6000);
    tick(2);
    chk("sb_empty_wrap", 32'(sb.size()), 32'd0);
    csr_rd(CSR_STATUS, rd); chk("status_resume", rd, st(2'b10, 0, 1, 7'd1));

    // Set of half 0 and ACK of half 1 in the same cycle
    stream(62, 16'h7000);
    bus.snk_valid = 1'b1; bus.snk_data = 16'h703E;
    bus.csr_chipselect = 1'b1; bus.csr_write = 1'b1;
    bus.csr_address = CSR_ACK; bus.csr_writedata = 32'h2;
    e.addr = mptr; e.data = 16'h703E; e.acc_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    bus.snk_valid = 1'b0; bus.csr_chipselect = 1'b0; bus.csr_write = 1'b0;
    mptr = mptr + 7'd1;
    csr_rd(CSR_STATUS, rd); chk("status_set_and_ack", rd, st(2'b01, 0, 1, 7'd64));
    stream(64, 16'h7100);
    chk("ready_stall2", 32'(bus.snk_ready), 32'd0);

    // Drop mode and saturation
    csr_wr(CSR_CTRL, 32'h3);
    tick(1);
    chk("irq_masked", 32'(bus.irq), 32'd0);
    chk("ready_drop", 32'(bus.snk_ready), 32'd1);
    for (int i = 0; i < 5; i++) send(16'hBEEF, 1'b0, 7'd0);
    tick(2);
    csr_rd(CSR_DROP, rd);   chk("drop_cnt_5", rd, 32'd5);
    csr_rd(CSR_STATUS, rd); chk("status_drop", rd, st(2'b11, 1, 0, 7'd0));
    bus.snk_valid = 1'b1;
    repeat (65530) @(negedge clk);
    bus.snk_valid = 1'b0;
    csr_rd(CSR_DROP, rd); chk("drop_cnt_max", rd, 32'h0000FFFF);
    for (int i = 0; i < 3; i++) send(16'hBEEF, 1'b0, 7'd0);
    csr_rd(CSR_DROP, rd); chk("drop_cnt_sat", rd, 32'h0000FFFF);

    // Clear, then clear racing an accept
    csr_wr(CSR_CTRL, 32'h9);
    tick(1);
    csr_rd(CSR_STATUS, rd); chk("status_clear", rd, st(2'b00, 0, 1, 7'd0));
    csr_rd(CSR_DROP, rd);   chk("drop_clear", rd, 32'd0);
    mptr = '0;
    stream(37, 16'h8000);
    chk("ready_pre_clear", 32'(bus.snk_ready), 32'd1);
    bus.snk_valid = 1'b1; bus.snk_data = 16'hDEAD;
    bus.csr_chipselect = 1'b1; bus.csr_write = 1'b1;
    bus.csr_address = CSR_CTRL; bus.csr_writedata = 32'h9;
    @(negedge clk);
    bus.snk_valid = 1'b0; bus.csr_chipselect = 1'b0; bus.csr_write = 1'b0;
    tick(2);
    csr_rd(CSR_STATUS, rd); chk("status_clear_race", rd, st(2'b00, 0, 1, 7'd0));
    csr_rd(CSR_CTRL, rd);   chk("ctrl_after_clear", rd, 32'h1);

    // Read and write of CTRL in the same cycle returns the old value
    bus.csr_chipselect = 1'b1; bus.csr_write = 1'b1; bus.csr_read = 1'b1;
    bus.csr_address = CSR_CTRL; bus.csr_writedata = 32'h5;
    @(negedge clk);
    rd = bus.csr_readdata;
    bus.csr_chipselect = 1'b0; bus.csr_write = 1'b0; bus.csr_read = 1'b0;
    chk("rw_same_cycle_old", rd, 32'h1);
    csr_rd(CSR_CTRL, rd); chk("rw_same_cycle_new", rd, 32'h5);

    // Reset mid-operation
    mptr = '0;
    stream(70, 16'h9000);
    tick(2);
    chk("irq_before_reset", 32'(bus.irq), 32'd1);
    csr_rd(CSR_STATUS, rd); chk("status_before_reset", rd, st(2'b01, 0, 1, 7'd70));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_ready", 32'(bus.snk_ready), 32'd0);
    chk("mid_rst_irq", 32'(bus.irq), 32'd0);
    chk("mid_rst_cs", 32'(bus.ram_chipselect), 32'd0);
    csr_rd(CSR_STATUS, rd); chk("mid_rst_status", rd, 32'd0);
    csr_rd(CSR_CTRL, rd);   chk("mid_rst_ctrl", rd, 32'd0);
    csr_rd(CSR_DROP, rd);   chk("mid_rst_drop", rd, 32'd0);
    csr_wr(CSR_CTRL, 32'h1);
    tick(1);
    mptr = '0;
    stream(1, 16'hA000);
    tick(2);
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
